// File: rtl/sdi_pkg.sv
// Shared constants, FSM state type and TRS helper for the SDI transmit framer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package sdi_pkg;

   localparam logic [9:0] TRS_3FF = 10'h3FF;
   localparam logic [9:0] TRS_000 = 10'h000;
   localparam logic [9:0] BLK_Y   = 10'h040;
   localparam logic [9:0] BLK_C   = 10'h200;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } sdi_state_t;

   // One SDI sample: luma and chroma words travel together.
   typedef struct packed {
      logic [9:0] y;
      logic [9:0] c;
   } sdi_word_t;

   // Fourth TRS word: fixed 1, F, V, H, then four protection bits, then 00.
   function automatic logic [9:0] xyz(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
   endfunction

endpackage

// File: rtl/sdi_tx_timing.sv
// Raster counters, run/stop FSM and horizontal/vertical region decode.
// Latency: decode outputs are combinational from the registered counters.
// Backpressure: none; the raster free-runs once started and never stalls.
//
// Ports: i_clk_148/i_rst_n clock and async reset; i_en run request;
//        running = FSM not IDLE; v_cnt line index; is_eav/is_sav/is_active
//        horizontal region; vblank = line is in the leading V=1 lines;
//        trs_idx = word index 0..3 inside EAV/SAV; frame_end = last word of frame.
module sdi_tx_timing
   import sdi_pkg::*;
#(
   parameter int H_ACTIVE = 1920,
   parameter int H_BLANK  = 326,
   parameter int V_TOTAL  = 1100,
   parameter int V_BLANK  = 20,
   parameter int LINE_W   = 12,
   parameter int H_W      = 12
) (
   input  logic              i_clk_148,
   input  logic              i_rst_n,
   input  logic              i_en,
   output logic              running,
   output logic [LINE_W-1:0] v_cnt,
   output logic              is_eav,
   output logic              is_sav,
   output logic              is_active,
   output logic              vblank,
   output logic [1:0]        trs_idx,
   output logic              frame_end
);

   localparam int H_TOTAL   = H_BLANK + H_ACTIVE + 8;
   localparam int SAV_START = H_BLANK + 4;
   localparam int ACT_START = H_BLANK + 8;

   sdi_state_t       state, state_nxt;
   logic [H_W-1:0]   h_cnt;
   logic [H_W-1:0]   sav_off;
   logic             h_last, v_last;

   assign running   = (state != IDLE);
   assign h_last    = (h_cnt == H_W'(H_TOTAL - 1));
   assign v_last    = (v_cnt == LINE_W'(V_TOTAL - 1));
   assign frame_end = running & h_last & v_last;

   assign is_eav    = (h_cnt < H_W'(4));
   assign is_sav    = (h_cnt >= H_W'(SAV_START)) && (h_cnt < H_W'(ACT_START));
   assign is_active = (h_cnt >= H_W'(ACT_START));
   assign vblank    = (v_cnt < LINE_W'(V_BLANK));
   assign sav_off   = h_cnt - H_W'(SAV_START);
   assign trs_idx   = is_eav ? h_cnt[1:0] : sav_off[1:0];

   // A stop request only takes effect at the frame end, so a frame is never
   // cut short; at that point i_en alone decides whether the next frame runs.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_en) state_nxt = RUN;
         end
         RUN: begin
            if (frame_end)  state_nxt = i_en ? RUN : IDLE;
            else if (!i_en) state_nxt = STOP_PEND;
         end
         STOP_PEND: begin
            if (frame_end) state_nxt = i_en ? RUN : IDLE;
            else if (i_en) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_148 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (!running) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdi_tx_framer.sv
// SDI 4:2:2 transmit framer: builds EAV/blank/SAV/active raster around upstream pixels.
// Latency: one cycle from counter position (and accepted pixel) to registered output word.
// Backpressure: o_ready paces upstream; a missing pixel is replaced by blank and flagged.
//
// Ports: i_clk_148/i_rst_n clock and async reset; i_en run request;
//        i_valid/i_y_data/i_cbcr_data upstream pixel pair, taken when o_ready;
//        o_y_data/o_cbcr_data SDI words; o_tx_sav/o_tx_eav/o_tx_trs word flags;
//        o_line_cnt line of the output word; o_frame_done/o_underflow pulses.
module sdi_tx_framer
   import sdi_pkg::*;
#(
   parameter int H_ACTIVE = 1920,
   parameter int H_BLANK  = 326,
   parameter int V_TOTAL  = 1100,
   parameter int V_BLANK  = 20,
   parameter int LINE_W   = 12
) (
   input  logic              i_clk_148,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [9:0]        i_y_data,
   input  logic [9:0]        i_cbcr_data,
   output logic              o_ready,
   output logic [9:0]        o_y_data,
   output logic [9:0]        o_cbcr_data,
   output logic              o_tx_sav,
   output logic              o_tx_eav,
   output logic              o_tx_trs,
   output logic [LINE_W-1:0] o_line_cnt,
   output logic              o_frame_done,
   output logic              o_underflow
);

   localparam int H_TOTAL = H_BLANK + H_ACTIVE + 8;
   localparam int H_W     = $clog2(H_TOTAL);

   logic              running;
   logic [LINE_W-1:0] v_cnt;
   logic              is_eav, is_sav, is_active, vblank, frame_end;
   logic [1:0]        trs_idx;

   sdi_word_t         word_nxt;
   logic [9:0]        xyz_w;
   logic              sav_nxt, eav_nxt, uf_nxt;

   sdi_tx_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_TOTAL  (V_TOTAL),
      .V_BLANK  (V_BLANK),
      .LINE_W   (LINE_W),
      .H_W      (H_W)
   ) u_timing (
      .i_clk_148 (i_clk_148),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .running   (running),
      .v_cnt     (v_cnt),
      .is_eav    (is_eav),
      .is_sav    (is_sav),
      .is_active (is_active),
      .vblank    (vblank),
      .trs_idx   (trs_idx),
      .frame_end (frame_end)
   );

   // Only registered state feeds o_ready, so upstream never sees a loop through i_valid.
   assign o_ready = running & is_active & ~vblank;

   // Progressive format: F is always 0.
   assign xyz_w = xyz(1'b0, vblank, is_eav);

   always_comb begin
      word_nxt = '{y: BLK_Y, c: BLK_C};
      sav_nxt  = 1'b0;
      eav_nxt  = 1'b0;
      uf_nxt   = 1'b0;
      if (running && (is_eav || is_sav)) begin
         sav_nxt = is_sav;
         eav_nxt = is_eav;
         case (trs_idx)
            2'd0:    word_nxt = '{y: TRS_3FF, c: TRS_3FF};
            2'd3:    word_nxt = '{y: xyz_w,   c: xyz_w};
            default: word_nxt = '{y: TRS_000, c: TRS_000};
         endcase
      end else if (o_ready) begin
         // Raster never waits: a missing pixel becomes a blank sample.
         if (i_valid) word_nxt = '{y: i_y_data, c: i_cbcr_data};
         else         uf_nxt   = 1'b1;
      end
   end

   always_ff @(posedge i_clk_148 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_y_data     <= BLK_Y;
         o_cbcr_data  <= BLK_C;
         o_tx_sav     <= 1'b0;
         o_tx_eav     <= 1'b0;
         o_tx_trs     <= 1'b0;
         o_line_cnt   <= '0;
         o_frame_done <= 1'b0;
         o_underflow  <= 1'b0;
      end else begin
         o_y_data     <= word_nxt.y;
         o_cbcr_data  <= word_nxt.c;
         o_tx_sav     <= sav_nxt;
         o_tx_eav     <= eav_nxt;
         o_tx_trs     <= sav_nxt | eav_nxt;
         o_line_cnt   <= v_cnt;
         o_frame_done <= frame_end;
         o_underflow  <= uf_nxt;
      end
   end

endmodule

// File: tb/tb_sdi_tx_framer.sv
// Self-checking bench for sdi_tx_framer on a reduced raster.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdi_tx_framer;

   localparam int HA = 16;
   localparam int HB = 6;
   localparam int VT = 12;
   localparam int VB = 3;
   localparam int LW = 12;
   localparam int HT = HA + HB + 8;
   localparam int FR = HT * VT;

   logic          clk = 1'b0;
   logic          i_rst_n, i_en, i_valid;
   logic [9:0]    i_y_data, i_cbcr_data;
   logic          o_ready, o_tx_sav, o_tx_eav, o_tx_trs, o_frame_done, o_underflow;
   logic [9:0]    o_y_data, o_cbcr_data;
   logic [LW-1:0] o_line_cnt;

   always #5 clk = ~clk;

   sdi_tx_framer #(
      .H_ACTIVE (HA), .H_BLANK (HB), .V_TOTAL (VT), .V_BLANK (VB), .LINE_W (LW)
   ) dut (
      .i_clk_148    (clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en),
      .i_valid      (i_valid),
      .i_y_data     (i_y_data),
      .i_cbcr_data  (i_cbcr_data),
      .o_ready      (o_ready),
      .o_y_data     (o_y_data),
      .o_cbcr_data  (o_cbcr_data),
      .o_tx_sav     (o_tx_sav),
      .o_tx_eav     (o_tx_eav),
      .o_tx_trs     (o_tx_trs),
      .o_line_cnt   (o_line_cnt),
      .o_frame_done (o_frame_done),
      .o_underflow  (o_underflow)
   );

   int vectors = 0;
   int errors  = 0;

   // model state: position inside the frame of the counters, and whether running
   bit         mrun;
   int         pos;
   logic [9:0] exp_y, exp_c;
   bit         exp_sav, exp_eav, exp_fd, exp_uf;
   int         exp_line;

   bit rst_drv, en_drv, rand_mode;
   int drop_left, ramp, cyc;
   int ready_cnt, uf_seen, fd_count;
   int fd_time [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [9:0] trs_word(input int idx, input bit eav, input bit vb);
      if (idx == 0) return 10'h3FF;
      if (idx == 3) return eav ? (vb ? 10'h2D8 : 10'h274) : (vb ? 10'h2AC : 10'h200);
      return 10'h000;
   endfunction

   task automatic set_exp_idle();
      exp_y = 10'h040; exp_c = 10'h200;
      exp_sav = 0; exp_eav = 0; exp_fd = 0; exp_uf = 0; exp_line = 0;
   endtask

   // One clock: check at the falling edge, drive new inputs, predict the next outputs.
   task automatic step();
      int h, v;
      bit vb, rdy, vld;
      logic [9:0] y, c;
      @(negedge clk);
      cyc++;
      h   = pos % HT;
      v   = pos / HT;
      vb  = (v < VB);
      rdy = mrun && (h >= HB + 8) && !vb;
      chk("ready", o_ready, rdy);
      chk("y", o_y_data, exp_y);
      chk("cbcr", o_cbcr_data, exp_c);
      chk("sav", o_tx_sav, exp_sav);
      chk("eav", o_tx_eav, exp_eav);
      chk("trs", o_tx_trs, exp_sav | exp_eav);
      chk("line", o_line_cnt, exp_line);
      chk("frame_done", o_frame_done, exp_fd);
      chk("underflow", o_underflow, exp_uf);
      if (o_ready === 1'b1) ready_cnt++;
      if (o_underflow === 1'b1) uf_seen++;
      if (o_frame_done === 1'b1) begin
         if (fd_count < 8) fd_time[fd_count] = cyc;
         fd_count++;
      end

      if (rand_mode) begin
         y   = 10'($urandom_range(0, 1023));
         c   = 10'($urandom_range(0, 1023));
         vld = ($urandom_range(0, 3) != 0);
      end else begin
         y   = ramp[9:0];
         c   = 10'(ramp + 512);
         vld = 1;
         ramp++;
      end
      if (rdy && drop_left > 0) begin
         vld = 0;
         drop_left--;
      end
      i_rst_n = rst_drv; i_en = en_drv; i_valid = vld; i_y_data = y; i_cbcr_data = c;

      set_exp_idle();
      if (!rst_drv) begin
         mrun = 0; pos = 0;
      end else if (!mrun) begin
         if (en_drv) begin mrun = 1; pos = 0; end
      end else begin
         exp_line = v;
         exp_fd   = (pos == FR - 1);
         if (h < 4) begin
            exp_eav = 1; exp_y = trs_word(h, 1, vb); exp_c = exp_y;
         end else if (h >= HB + 4 && h < HB + 8) begin
            exp_sav = 1; exp_y = trs_word(h - HB - 4, 0, vb); exp_c = exp_y;
         end else if (rdy) begin
            if (vld) begin exp_y = y; exp_c = c; end
            else exp_uf = 1;
         end
         if (pos == FR - 1) begin pos = 0; mrun = en_drv; end
         else pos++;
      end
   endtask

   task automatic run_until(input int n);
      for (int i = 0; i < 3 * FR && fd_count < n; i++) step();
      if (fd_count < n) begin
         vectors++; errors++;
         $display("FAIL frame_done_timeout: got %0d pulses, expected %0d", fd_count, n);
      end
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      i_rst_n = 0; rst_drv = 0;
      #1;
      chk("arst_y", o_y_data, 10'h040);
      chk("arst_cbcr", o_cbcr_data, 10'h200);
      chk("arst_trs", {o_tx_sav, o_tx_eav, o_tx_trs}, 3'b000);
      chk("arst_ready", o_ready, 1'b0);
      chk("arst_line", o_line_cnt, 0);
      chk("arst_pulses", {o_frame_done, o_underflow}, 2'b00);
      mrun = 0; pos = 0;
      set_exp_idle();
   endtask

   initial begin
      rst_drv = 0; en_drv = 0; rand_mode = 0; drop_left = 0; ramp = 0; cyc = 0;
      ready_cnt = 0; uf_seen = 0; fd_count = 0;
      i_rst_n = 0; i_en = 0; i_valid = 0; i_y_data = '0; i_cbcr_data = '0;
      mrun = 0; pos = 0;
      set_exp_idle();

      repeat (3) step();
      chk("rst_y", o_y_data, 10'h040);
      chk("rst_cbcr", o_cbcr_data, 10'h200);
      chk("rst_flags", {o_tx_sav, o_tx_eav, o_tx_trs, o_ready}, 4'b0000);
      chk("rst_line", o_line_cnt, 0);

      rst_drv = 1;
      repeat (4) step();

      // Start: first frame with a ramp and five dropped pixels.
      en_drv = 1;
      repeat (3) step();
      chk("first_eav_y", o_y_data, 10'h3FF);
      chk("first_eav_flag", {o_tx_eav, o_tx_trs}, 2'b11);
      chk("first_line", o_line_cnt, 0);
      repeat (3) step();
      chk("first_xyz_y", o_y_data, 10'h2D8);
      chk("first_xyz_c", o_cbcr_data, 10'h2D8);
      drop_left = 5;
      run_until(1);
      chk("ready_cycles", ready_cnt, (VT - VB) * HA);
      chk("underflow_pulses", uf_seen, 5);

      // Second frame back to back with random data and random valid.
      rand_mode = 1;
      run_until(2);
      chk("frame_period", fd_time[1] - fd_time[0], FR);

      // Third frame: stop request, brief resume, stop again; frame completes.
      repeat (5 * HT) step();
      en_drv = 0;
      repeat (10) step();
      en_drv = 1;
      repeat (5) step();
      en_drv = 0;
      run_until(3);
      chk("stop_full_frame", fd_time[2] - fd_time[1], FR);
      repeat (40) step();
      chk("idle_y", o_y_data, 10'h040);
      chk("idle_ready", o_ready, 1'b0);
      chk("frame_done_once", fd_count, 3);

      // Restart from idle.
      en_drv = 1;
      repeat (3) step();
      chk("restart_y", o_y_data, 10'h3FF);
      chk("restart_line", o_line_cnt, 0);

      // Asynchronous reset in the middle of an active line.
      repeat (4 * HT + HB + 12) step();
      async_reset();
      repeat (2) step();
      rst_drv = 1;
      repeat (3) step();
      chk("post_rst_y", o_y_data, 10'h3FF);
      chk("post_rst_eav", o_tx_eav, 1'b1);
      chk("post_rst_line", o_line_cnt, 0);
      run_until(5);
      chk("post_rst_period", fd_time[4] - fd_time[3], FR);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
